pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/cpu_types_pkg.sv | 52 +++++
 rtl/pipeline_ctrl_if.sv | 41 ++++
 rtl/sat_counter.sv | 27 ++
 rtl/pipeline_ctrl.sv | 90 +++++++++
 tb/tb_pipeline_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline controller.
//   pipe_state_t : controller FSM states (RUN, MEMWAIT, HALT)
//   pipe_ctrl_t  : bundle of the five latch enables plus the two flush requests
//   run_rules()  : enable/flush pattern for a cycle not frozen by halt or a memory miss
package cpu_types_pkg;

    localparam int unsigned CNT_WIDTH = 32;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALT    = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
    } pipe_ctrl_t;

    // Everything frozen, no bubbles.
    localparam pipe_ctrl_t CTRL_FREEZE = pipe_ctrl_t'(7'b0000000);
    // Held in reset: latches closed, both bubbles requested.
    localparam pipe_ctrl_t CTRL_RESET  = pipe_ctrl_t'(7'b0000011);
    // Normal flow.
    localparam pipe_ctrl_t CTRL_NORMAL = pipe_ctrl_t'(7'b1111100);

    // Priority: hazard > branch/jump > fetch miss > normal.
    function automatic pipe_ctrl_t run_rules(input logic hazard, input logic branch,
                                             input logic jump, input logic ihit);
        pipe_ctrl_t c;
        c = CTRL_NORMAL;
        if (hazard) begin
            // Hold PC and IF/ID, push a bubble into ID/EX; a branch in ID is re-evaluated later.
            c.pc_en      = 1'b0;
            c.ifid_en    = 1'b0;
            c.idex_flush = 1'b1;
        end else if (branch || jump) begin
            // PC loads the target even while the fetch is still pending.
            c.ifid_flush = 1'b1;
        end else if (!ihit) begin
            c.pc_en      = 1'b0;
            c.ifid_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline controller and its environment.
//   inputs to ctrl : hazard, branch, jump, ihit, dhit, dmemREN, dmemWEN, halt
//   outputs of ctrl: pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
//                    halted, stall_cnt, flush_cnt, state (observability of the FSM)
interface pipeline_ctrl_if;
    import cpu_types_pkg::*;

    logic                 hazard;
    logic                 branch;
    logic                 jump;
    logic                 ihit;
    logic                 dhit;
    logic                 dmemREN;
    logic                 dmemWEN;
    logic                 halt;

    logic                 pc_en;
    logic                 ifid_en;
    logic                 idex_en;
    logic                 exmem_en;
    logic                 memwb_en;
    logic                 ifid_flush;
    logic                 idex_flush;
    logic                 halted;
    logic [CNT_WIDTH-1:0] stall_cnt;
    logic [CNT_WIDTH-1:0] flush_cnt;
    pipe_state_t          state;

    modport ctrl (
        input  hazard, branch, jump, ihit, dhit, dmemREN, dmemWEN, halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
        output halted, stall_cnt, flush_cnt, state
    );

    modport tb (
        output hazard, branch, jump, ihit, dhit, dmemREN, dmemWEN, halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
        input  halted, stall_cnt, flush_cnt, state
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   i_clk   : clock
//   i_clear : synchronous clear, wins over i_inc
//   i_inc   : increment request; ignored once the count is all-ones
//   o_count : current count
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller for a 5-stage pipeline.
//   CLK, RST : clock and synchronous active-high reset
//   bus      : pipeline_ctrl_if.ctrl -- hazard/branch/jump/ihit/dhit/dmem*/halt in,
//              latch enables, flushes, halted, stall/flush counters and FSM state out
// Outputs are combinational from the registered state and this cycle's inputs.
module pipeline_ctrl
    import cpu_types_pkg::*;
(
    input logic           CLK,
    input logic           RST,
    pipeline_ctrl_if.ctrl bus
);

    pipe_state_t r_state;
    pipe_state_t w_state_d;
    pipe_ctrl_t  w_ctrl;
    logic        w_miss;
    logic        w_stall_inc;
    logic        w_flush_inc;

    assign w_miss = (bus.dmemREN || bus.dmemWEN) && !bus.dhit;

    always_comb begin
        w_ctrl    = CTRL_FREEZE;
        w_state_d = r_state;
        if (RST) begin
            w_ctrl    = CTRL_RESET;
            w_state_d = RUN;
        end else begin
            unique case (r_state)
                RUN, MEMWAIT: begin
                    // In MEMWAIT the miss term collapses to !dhit, so both states share one path.
                    if (r_state == MEMWAIT && !bus.dhit) begin
                        w_state_d = MEMWAIT;
                    end else if (bus.halt) begin
                        w_state_d = HALT;
                    end else if (w_miss) begin
                        w_state_d = MEMWAIT;
                    end else begin
                        w_ctrl    = run_rules(bus.hazard, bus.branch, bus.jump, bus.ihit);
                        w_state_d = RUN;
                    end
                end
                HALT: w_state_d = HALT;
                default: w_state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_d;
        end
    end

    assign bus.pc_en      = w_ctrl.pc_en;
    assign bus.ifid_en    = w_ctrl.ifid_en;
    assign bus.idex_en    = w_ctrl.idex_en;
    assign bus.exmem_en   = w_ctrl.exmem_en;
    assign bus.memwb_en   = w_ctrl.memwb_en;
    assign bus.ifid_flush = w_ctrl.ifid_flush;
    assign bus.idex_flush = w_ctrl.idex_flush;
    assign bus.halted     = (r_state == HALT) && !RST;
    assign bus.state      = r_state;

    // Counters freeze in HALT; RST clears and takes precedence over counting.
    assign w_stall_inc = !w_ctrl.pc_en && (r_state != HALT);
    assign w_flush_inc = (w_ctrl.ifid_flush || w_ctrl.idex_flush) && (r_state != HALT);

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_stall_cnt (
        .i_clk  (CLK),
        .i_clear(RST),
        .i_inc  (w_stall_inc),
        .o_count(bus.stall_cnt)
    );

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_flush_cnt (
        .i_clk  (CLK),
        .i_clear(RST),
        .i_inc  (w_flush_inc),
        .o_count(bus.flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl. Inputs change 1 time unit after the rising edge,
// combinational outputs are checked 1 unit later, well clear of the next edge.
module tb_pipeline_ctrl;
    import cpu_types_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    pipeline_ctrl_if bus ();

    pipeline_ctrl dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus.ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}
    localparam logic [6:0] E_NORMAL = 7'b1111100;
    localparam logic [6:0] E_FREEZE = 7'b0000000;
    localparam logic [6:0] E_RESET  = 7'b0000011;
    localparam logic [6:0] E_HAZARD = 7'b0011101;
    localparam logic [6:0] E_BRANCH = 7'b1111110;
    localparam logic [6:0] E_IMISS  = 7'b0111110;

    function automatic logic [31:0] ctrl_vec();
        return {25'd0, bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                bus.ifid_flush, bus.idex_flush};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic hz, input logic br, input logic jp, input logic ih,
                          input logic dh, input logic dr, input logic dw, input logic hl);
        bus.hazard  = hz;
        bus.branch  = br;
        bus.jump    = jp;
        bus.ihit    = ih;
        bus.dhit    = dh;
        bus.dmemREN = dr;
        bus.dmemWEN = dw;
        bus.halt    = hl;
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset held: latches closed, both bubbles, not halted.
        chk("rst_ctrl", ctrl_vec(), 32'(E_RESET));
        chk("rst_halted", 32'(bus.halted), 32'd0);
        cyc();
        cyc();
        chk("rst_state", 32'(bus.state), 32'(RUN));
        chk("rst_stall", bus.stall_cnt, 32'd0);
        chk("rst_flush", bus.flush_cnt, 32'd0);

        // Normal flow for 10 cycles.
        rst = 1'b0;
        set_in(0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            chk("normal_ctrl", ctrl_vec(), 32'(E_NORMAL));
            cyc();
        end
        chk("normal_stall", bus.stall_cnt, 32'd0);
        chk("normal_flush", bus.flush_cnt, 32'd0);

        // Load miss for 3 cycles, then dhit.
        set_in(0, 0, 0, 1, 0, 1, 0, 0);
        chk("miss1_ctrl", ctrl_vec(), 32'(E_FREEZE));
        cyc();
        chk("miss2_state", 32'(bus.state), 32'(MEMWAIT));
        chk("miss2_ctrl", ctrl_vec(), 32'(E_FREEZE));
        cyc();
        chk("miss3_ctrl", ctrl_vec(), 32'(E_FREEZE));
        cyc();
        set_in(0, 0, 0, 1, 1, 1, 0, 0);
        chk("dhit_state", 32'(bus.state), 32'(MEMWAIT));
        chk("dhit_ctrl", ctrl_vec(), 32'(E_NORMAL));
        chk("miss_stall", bus.stall_cnt, 32'd3);
        cyc();
        chk("dhit_back_run", 32'(bus.state), 32'(RUN));
        chk("miss_stall_after", bus.stall_cnt, 32'd3);

        // Hazard + branch + fetch miss: hazard row exactly.
        set_in(1, 1, 0, 0, 0, 0, 0, 0);
        chk("hz_br_ctrl", ctrl_vec(), 32'(E_HAZARD));
        cyc();
        chk("hz_stall", bus.stall_cnt, 32'd4);
        chk("hz_flush", bus.flush_cnt, 32'd1);
        set_in(0, 1, 0, 1, 0, 0, 0, 0);
        chk("branch_ctrl", ctrl_vec(), 32'(E_BRANCH));
        cyc();
        set_in(0, 0, 1, 0, 0, 0, 0, 0);
        chk("jump_noihit_ctrl", ctrl_vec(), 32'(E_BRANCH));
        cyc();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        chk("imiss_ctrl", ctrl_vec(), 32'(E_IMISS));
        cyc();
        chk("br_stall", bus.stall_cnt, 32'd5);
        chk("br_flush", bus.flush_cnt, 32'd4);

        // Store miss outranks hazard; hazard row applies on the dhit cycle.
        set_in(1, 0, 0, 1, 0, 0, 1, 0);
        chk("st_miss_ctrl", ctrl_vec(), 32'(E_FREEZE));
        cyc();
        chk("st_miss_state", 32'(bus.state), 32'(MEMWAIT));
        set_in(1, 0, 0, 1, 1, 0, 1, 0);
        chk("st_dhit_hz_ctrl", ctrl_vec(), 32'(E_HAZARD));
        cyc();
        chk("st_dhit_state", 32'(bus.state), 32'(RUN));
        chk("st_stall", bus.stall_cnt, 32'd7);
        chk("st_flush", bus.flush_cnt, 32'd5);

        // Halt outranks a pending miss; sticky, counters frozen.
        set_in(0, 0, 0, 1, 0, 1, 0, 1);
        chk("halt_ctrl", ctrl_vec(), 32'(E_FREEZE));
        chk("halt_not_yet", 32'(bus.halted), 32'd0);
        cyc();
        chk("halted_set", 32'(bus.halted), 32'd1);
        chk("halt_state", 32'(bus.state), 32'(HALT));
        set_in(1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            chk("halt_hold_ctrl", ctrl_vec(), 32'(E_FREEZE));
            cyc();
        end
        chk("halt_hold_halted", 32'(bus.halted), 32'd1);
        chk("halt_stall", bus.stall_cnt, 32'd8);
        chk("halt_flush", bus.flush_cnt, 32'd5);
        rst = 1'b1;
        #1;
        chk("halt_rst_halted", 32'(bus.halted), 32'd0);
        chk("halt_rst_ctrl", ctrl_vec(), 32'(E_RESET));
        cyc();
        chk("halt_rst_state", 32'(bus.state), 32'(RUN));
        chk("halt_rst_stall", bus.stall_cnt, 32'd0);
        chk("halt_rst_flush", bus.flush_cnt, 32'd0);

        // Reset taken from MEMWAIT.
        rst = 1'b0;
        set_in(0, 0, 0, 1, 0, 1, 0, 0);
        cyc();
        chk("mw_state", 32'(bus.state), 32'(MEMWAIT));
        chk("mw_stall", bus.stall_cnt, 32'd1);
        rst = 1'b1;
        cyc();
        chk("mw_rst_state", 32'(bus.state), 32'(RUN));
        chk("mw_rst_stall", bus.stall_cnt, 32'd0);

        // Saturation of the stall counter.
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        force dut.u_stall_cnt.r_count = 32'hFFFF_FFFE;
        #1;
        release dut.u_stall_cnt.r_count;
        cyc();
        chk("sat_first", bus.stall_cnt, 32'hFFFF_FFFF);
        cyc();
        cyc();
        chk("sat_hold", bus.stall_cnt, 32'hFFFF_FFFF);
        chk("sat_flush", bus.flush_cnt, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
